// File: rtl/prom_boot_reader.sv
// prom_boot_reader: reads NUM_WORDS microwords byte-by-byte from a 512x8 PROM at boot; trailing checksum verify under PROM_READER_CHECKSUM_EN
module prom_boot_reader #(
  parameter int WORD_BYTES    = 6,
  parameter int NUM_WORDS     = 64,
  parameter int ACCESS_CYCLES = 2,
  parameter int START_ADDR    = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic [8:0]              prom_a,
  output logic                    prom_ce_n,
  input  logic [7:0]              prom_d,
  output logic [8*WORD_BYTES-1:0] out_word,
  output logic [8:0]              out_addr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    sum_err
);
  localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_PRESENT = 3'd2;
  localparam logic [2:0] S_CHECK   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [3:0] CNT_LOAD   = 4'(ACCESS_CYCLES);
  localparam logic [BW-1:0] LAST_BYTE = BW'(WORD_BYTES - 1);
  localparam logic [8:0] LAST_WORD  = 9'(NUM_WORDS - 1);
  localparam logic [8:0] FIRST_ADDR = 9'(START_ADDR);
  logic [2:0]              r_state;
  logic [3:0]              r_cnt;
  logic [BW-1:0]           r_byte;
  logic [8:0]              r_a;
  logic [8:0]              r_idx;
  logic [8*WORD_BYTES-1:0] r_word;
  logic                    w_fetching;
  logic                    w_tick;
  logic [2:0]              w_after_last;
`ifdef PROM_READER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic       r_sum_err;
  assign w_fetching   = (r_state == S_FETCH) || (r_state == S_CHECK);
  assign w_after_last = S_CHECK;
  // Running modulo-256 sum of every captured byte; verdict when the trailing checksum byte lands
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum     <= 8'd0;
      r_sum_err <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_sum     <= 8'd0;
      r_sum_err <= 1'b0;
    end else if (w_tick) begin
      r_sum <= 8'(r_sum + prom_d);
      if (r_state == S_CHECK) r_sum_err <= 8'(r_sum + prom_d) != 8'd0;
    end
  end
  assign sum_err = r_sum_err;
`else
  assign w_fetching   = r_state == S_FETCH;
  assign w_after_last = S_DONE;
  assign sum_err      = 1'b0;
`endif
  assign w_tick    = w_fetching && (r_cnt == 4'd1);
  assign prom_a    = r_a;
  assign prom_ce_n = !w_fetching;
  assign out_word  = r_word;
  assign out_addr  = r_idx;
  assign out_valid = r_state == S_PRESENT;
  assign busy      = r_state != S_IDLE;
  assign done      = r_state == S_DONE;
  // Boot sequencer: byte fetch with access-time countdown, word hand-off, completion
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_byte  <= '0;
      r_a     <= 9'd0;
      r_idx   <= 9'd0;
      r_word  <= '0;
    end else if (r_state == S_IDLE) begin
      if (start) begin
        r_state <= S_FETCH;
        r_a     <= FIRST_ADDR;
        r_byte  <= '0;
        r_idx   <= 9'd0;
        r_cnt   <= CNT_LOAD;
      end
    end else if (w_fetching) begin
      r_cnt <= w_tick ? CNT_LOAD : 4'(r_cnt - 4'd1);
      if (w_tick) begin
        r_a <= 9'(r_a + 9'd1);
        if (r_state == S_CHECK) begin
          r_state <= S_DONE;
        end else begin
          r_word[8*r_byte +: 8] <= prom_d;
          r_byte  <= (r_byte == LAST_BYTE) ? r_byte : BW'(r_byte + BW'(1));
          r_state <= (r_byte == LAST_BYTE) ? S_PRESENT : S_FETCH;
        end
      end
    end else if (r_state == S_PRESENT) begin
      if (out_ready) begin
        if (r_idx == LAST_WORD) begin
          r_state <= w_after_last;
        end else begin
          r_idx   <= 9'(r_idx + 9'd1);
          r_byte  <= '0;
          r_state <= S_FETCH;
        end
      end
    end else begin
      r_state <= S_IDLE;
    end
  end
endmodule

// File: doc/prom_boot_reader.md
PROM_BOOT_READER -- requirements
Module: prom_boot_reader

Interface
REQ-001 The block SHALL declare parameter WORD_BYTES, default 6, giving the number of PROM bytes packed per output word (48-bit microword).
REQ-002 The block SHALL declare parameter NUM_WORDS, default 64, giving the number of words read per boot; WORD_BYTES*NUM_WORDS SHALL NOT exceed 511.
REQ-003 The block SHALL declare parameter ACCESS_CYCLES, default 2 (range 1-15), giving the clocks from address/enable valid to data sample.
REQ-004 The block SHALL declare parameter START_ADDR, default 0, giving the first PROM byte address.
REQ-005 The block SHALL have these ports: clk, input, 1, the only clock; all state changes on its rising edge.
REQ-006 reset, input, 1, synchronous, active-high.
REQ-007 start, input, 1, one-cycle request to begin a boot read.
REQ-008 prom_a, output, 9, byte address to the 512x8 PROM.
REQ-009 prom_ce_n, output, 1, active-low PROM chip enable.
REQ-010 prom_d, input, 8, PROM data, valid ACCESS_CYCLES clocks after prom_a/prom_ce_n.
REQ-011 out_word, output, 8*WORD_BYTES, assembled word; byte 0 (lowest address) in bits [7:0].
REQ-012 out_addr, output, 9, word index (0..NUM_WORDS-1) of out_word.
REQ-013 out_valid, output, 1; out_ready, input, 1: downstream write handshake.
REQ-014 busy, output, 1, high from start acceptance until DONE exits; done, output, 1, one-cycle completion pulse.
REQ-015 sum_err, output, 1, checksum failure flag (present only with PROM_READER_CHECKSUM_EN; tied 0 otherwise).

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, PRESENT, CHECK, DONE.
REQ-017 In IDLE, start=1 SHALL load prom_a=START_ADDR, byte index 0, word index 0, wait counter=ACCESS_CYCLES, and enter FETCH next cycle.
REQ-018 start SHALL be ignored in every state other than IDLE.
REQ-019 In FETCH, prom_ce_n SHALL be 0; the counter SHALL decrement each cycle and prom_d SHALL be captured into byte slot [byte index] on the cycle the counter equals 1.
REQ-020 On capture prom_a SHALL increment by 1 and the counter SHALL reload; if byte index was WORD_BYTES-1 the FSM SHALL enter PRESENT, else byte index increments and FETCH continues.
REQ-021 In every state except FETCH (and CHECK fetch, REQ-030), prom_ce_n SHALL be 1; prom_a SHALL hold its value.
REQ-022 In PRESENT, out_valid SHALL be 1 and out_word/out_addr SHALL be stable until out_valid&out_ready.
REQ-023 On transfer, if word index < NUM_WORDS-1 the word index SHALL increment, byte index clear, and FSM re-enter FETCH; else FSM SHALL enter CHECK (macro defined) or DONE.
REQ-024 out_ready SHALL be ignored outside PRESENT; out_valid SHALL never be 1 outside PRESENT.
REQ-025 DONE SHALL last exactly one cycle with done=1, then return to IDLE; busy SHALL be 0 only in IDLE.
REQ-026 A transfer of NUM_WORDS words SHALL take exactly NUM_WORDS*(WORD_BYTES*ACCESS_CYCLES+1)+2 cycles from start to done with out_ready held 1 (macro off).

Reset
REQ-027 reset=1 SHALL, at the next clock edge and overriding any state, force IDLE, prom_a=0, prom_ce_n=1, out_word=0, out_addr=0, out_valid=0, busy=0, done=0, sum_err=0, counters=0.
REQ-028 reset asserted mid-FETCH or mid-PRESENT SHALL abort the read with no further out_valid; a start after reset SHALL restart from START_ADDR.

Configuration
REQ-029 Macro PROM_READER_CHECKSUM_EN, when defined, SHALL keep an 8-bit modulo-256 running sum of every captured byte, cleared on start.
REQ-030 With it defined, CHECK SHALL fetch one extra byte at START_ADDR+WORD_BYTES*NUM_WORDS using FETCH timing, add it to the sum, set sum_err=1 if the result is nonzero, then enter DONE; sum_err SHALL hold until next start or reset.
REQ-031 Without it, CHECK SHALL be unreachable, no checksum logic SHALL exist, and sum_err SHALL be constant 0.

Verification
REQ-032 PROM[n]=n, WORD_BYTES=6, NUM_WORDS=2, ACCESS_CYCLES=2, out_ready=1, start -> word0=48'h050403020100 addr 0, word1=48'h0B0A09080706 addr 1, done at cycle 28.
REQ-033 Same, out_ready=0 for 10 cycles in first PRESENT -> out_valid held, out_word stable, prom_ce_n=1, no prom_a change; word1 unchanged after release.
REQ-034 start pulsed again during FETCH -> ignored; exactly NUM_WORDS transfers, one done pulse.
REQ-035 reset asserted during second word FETCH -> next cycle all outputs at reset values; subsequent start re-reads from address 0, word0 correct.
REQ-036 Macro defined, PROM[0..11]=n, PROM[12]=8'hBE (sum 66+0xBE=0x00) -> sum_err=0; PROM[12]=8'h00 -> sum_err=1 after done.
REQ-037 ACCESS_CYCLES=1, START_ADDR=500, NUM_WORDS=1, WORD_BYTES=6 -> prom_a steps 500..505, one word, no address wrap past 511.
